// File: rtl/imm_encoder.sv
// imm_encoder: packs decoded RV32I fields into an instruction word through a 2-stage valid/ready pipeline.
// Range/alignment faults and unknown opcodes emit NOP_INST with out_err and bump a saturating counter.
module imm_encoder #(
    parameter int          ERR_CNT_W = 16,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    logic                 s1_valid_q, s1_err_q, s1_err_d;
    logic [6:0]           op_q, f7_q;
    logic [4:0]           rd_q, rs1_q, rs2_q;
    logic [2:0]           f3_q;
    logic [31:0]          imm_q, inst_d, out_inst_q;
    logic                 out_valid_q, out_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic                 s1_adv, s2_adv, i_ok, b_ok, j_ok;

    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

    // Sign-extension checks: every bit above the field's sign bit must match it.
    assign i_ok = &in_imm[31:11] || ~|in_imm[31:11];
    assign b_ok = (&in_imm[31:12] || ~|in_imm[31:12]) && !in_imm[0];
    assign j_ok = (&in_imm[31:20] || ~|in_imm[31:20]) && !in_imm[0];

    always_comb begin
        s1_err_d = 1'b1;
        case (in_opcode)
            OP_R:                          s1_err_d = 1'b0;
            OP_I, OP_LD, OP_JALR, OP_S:    s1_err_d = !i_ok;
            OP_B:                          s1_err_d = !b_ok;
            OP_J:                          s1_err_d = !j_ok;
            default:                       s1_err_d = 1'b1;
        endcase
    end

    // Unsupported opcodes already carry s1_err_q, so the default arm only sees I-type.
    always_comb begin
        inst_d = NOP_INST;
        if (!s1_err_q) begin
            case (op_q)
                OP_R:    inst_d = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
                OP_S:    inst_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                OP_B:    inst_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
                OP_J:    inst_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                default: inst_d = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            op_q        <= '0;
            f7_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            f3_q        <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_err_q <= s1_err_d;
                    op_q     <= in_opcode;
                    f7_q     <= in_funct7;
                    rd_q     <= in_rd;
                    rs1_q    <= in_rs1;
                    rs2_q    <= in_rs2;
                    f3_q     <= in_funct3;
                    imm_q    <= in_imm;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q <= inst_d;
                    out_err_q  <= s1_err_q;
                end
            end
            if (out_valid_q && out_ready && out_err_q && !(&err_count_q))
                err_count_q <= err_count_q + ERR_CNT_W'(1);
        end
    end
endmodule
